// File: rtl/rf_sched_pkg.sv
// Shared constants and types for the register-file write-back scheduler.
package rf_sched_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned NREG   = 16;
   localparam int unsigned CNT_W  = 2;

   localparam logic [ADDR_W-1:0] R0_ADDR = '0;
   localparam logic [CNT_W-1:0]  CNT_MAX = 2'd3;

   typedef enum logic {GNT_A, GNT_D} gnt_e;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Write-back requesters, issue/operand-check port and register-file write port.
interface rf_wb_scheduler_if;
   import rf_sched_pkg::*;

   logic              in_a_valid;
   logic [ADDR_W-1:0] in_a_addr;
   logic [DATA_W-1:0] in_a_data;
   logic              out_a_ready;
   logic              in_d_valid;
   logic [DATA_W-1:0] in_d_data;
   logic              out_d_ready;
   logic              in_iss_valid;
   logic [ADDR_W-1:0] in_iss_addr;
   logic              out_iss_ready;
   logic [ADDR_W-1:0] in_chk_op1_addr;
   logic [ADDR_W-1:0] in_chk_op2_addr;
   logic              out_stall;
   logic              out_we;
   logic [ADDR_W-1:0] out_waddr;
   logic [DATA_W-1:0] out_wdata;
   logic [NREG-1:0]   out_busy;
   logic              out_err;

   modport master (
      output in_a_valid, in_a_addr, in_a_data, in_d_valid, in_d_data,
             in_iss_valid, in_iss_addr, in_chk_op1_addr, in_chk_op2_addr,
      input  out_a_ready, out_d_ready, out_iss_ready, out_stall,
             out_we, out_waddr, out_wdata, out_busy, out_err
   );

   modport slave (
      input  in_a_valid, in_a_addr, in_a_data, in_d_valid, in_d_data,
             in_iss_valid, in_iss_addr, in_chk_op1_addr, in_chk_op2_addr,
      output out_a_ready, out_d_ready, out_iss_ready, out_stall,
             out_we, out_waddr, out_wdata, out_busy, out_err
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-write counters: issue increments, write-back decrements,
// saturation back-pressure on issue, busy/stall and sticky underflow error.
module rf_scoreboard
   import rf_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wb_valid_i,
   input  logic [ADDR_W-1:0] wb_addr_i,
   input  logic              iss_valid_i,
   input  logic [ADDR_W-1:0] iss_addr_i,
   input  logic [ADDR_W-1:0] chk_op1_addr_i,
   input  logic [ADDR_W-1:0] chk_op2_addr_i,
   output logic              iss_ready_o,
   output logic              stall_o,
   output logic [NREG-1:0]   busy_o,
   output logic              err_o
);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [CNT_W-1:0] cnt_d [NREG];
   logic             err_q, err_d;
   logic             iss_fire;

   always_comb begin
      // A saturated register can still be claimed when its write-back lands this cycle.
      iss_ready_o = (cnt_q[iss_addr_i] != CNT_MAX) || (wb_valid_i && (wb_addr_i == iss_addr_i));
      iss_fire    = iss_valid_i && iss_ready_o;
      err_d       = err_q | (wb_valid_i && (cnt_q[wb_addr_i] == '0));
      for (int i = 0; i < NREG; i++) begin
         cnt_d[i] = cnt_q[i];
         if (iss_fire && (iss_addr_i == ADDR_W'(i)) &&
             !(wb_valid_i && (wb_addr_i == ADDR_W'(i)))) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end else if (wb_valid_i && (wb_addr_i == ADDR_W'(i)) &&
                      !(iss_fire && (iss_addr_i == ADDR_W'(i))) && (cnt_q[i] != '0)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      busy_o = '0;
      for (int i = 0; i < NREG; i++) begin
         busy_o[i] = (cnt_q[i] != '0);
      end
   end

   assign stall_o = busy_o[chk_op1_addr_i] | busy_o[chk_op2_addr_i];
   assign err_o   = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREG; i++) begin
            cnt_q[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Round-robin arbiter for the single register-file write port, registered write
// port and the outstanding-write scoreboard used for decode RAW stalls.
module rf_wb_scheduler
   import rf_sched_pkg::*;
(
   input logic              CLOCK,
   input logic              in_rst,
   rf_wb_scheduler_if.slave bus
);

   gnt_e              last_grant_q, last_grant_d;
   logic              a_gnt, d_gnt, wb_fire;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      a_gnt = bus.in_a_valid;
      d_gnt = bus.in_d_valid;
      if (bus.in_a_valid && bus.in_d_valid) begin
         a_gnt = (last_grant_q == GNT_D);
         d_gnt = !a_gnt;
      end
      wb_fire = a_gnt | d_gnt;
      wb_addr = a_gnt ? bus.in_a_addr : R0_ADDR;
      wb_data = a_gnt ? bus.in_a_data : bus.in_d_data;

      last_grant_d = last_grant_q;
      if (wb_fire) begin
         last_grant_d = a_gnt ? GNT_A : GNT_D;
      end

      // Address/data hold their last value when idle; only out_we marks a write.
      we_d    = wb_fire;
      waddr_d = wb_fire ? wb_addr : waddr_q;
      wdata_d = wb_fire ? wb_data : wdata_q;
   end

   always_ff @(posedge CLOCK or posedge in_rst) begin
      if (in_rst) begin
         last_grant_q <= GNT_D;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign bus.out_a_ready = a_gnt;
   assign bus.out_d_ready = d_gnt;
   assign bus.out_we      = we_q;
   assign bus.out_waddr   = waddr_q;
   assign bus.out_wdata   = wdata_q;

   rf_scoreboard u_scoreboard (
      .clk_i          (CLOCK),
      .rst_i          (in_rst),
      .wb_valid_i     (wb_fire),
      .wb_addr_i      (wb_addr),
      .iss_valid_i    (bus.in_iss_valid),
      .iss_addr_i     (bus.in_iss_addr),
      .chk_op1_addr_i (bus.in_chk_op1_addr),
      .chk_op2_addr_i (bus.in_chk_op2_addr),
      .iss_ready_o    (bus.out_iss_ready),
      .stall_o        (bus.out_stall),
      .busy_o         (bus.out_busy),
      .err_o          (bus.out_err)
   );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed scenarios plus a randomized run against a pending-count reference model.
module tb_rf_wb_scheduler;
   import rf_sched_pkg::*;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   rf_wb_scheduler_if bus ();

   rf_wb_scheduler dut (
      .CLOCK  (clk),
      .in_rst (rst),
      .bus    (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: pending-write count per register, preferred requester,
   // sticky error and the write expected on the register-file port.
   int          m_cnt [16];
   bit          m_last_d;
   bit          m_err;
   bit          m_we;
   int          m_waddr;
   int          m_wdata;
   bit          m_ga, m_gd, m_wb, m_iss_rdy, m_stall;
   int          m_wbaddr, m_wbdata;

   task automatic model_reset();
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_last_d = 1'b1;
      m_err    = 1'b0;
      m_we     = 1'b0;
      m_waddr  = 0;
      m_wdata  = 0;
   endtask

   task automatic model_comb();
      m_ga = 1'b0;
      m_gd = 1'b0;
      if (bus.in_a_valid && bus.in_d_valid) begin
         if (m_last_d) m_ga = 1'b1;
         else m_gd = 1'b1;
      end else begin
         m_ga = bus.in_a_valid;
         m_gd = bus.in_d_valid;
      end
      m_wb      = m_ga || m_gd;
      m_wbaddr  = m_ga ? int'(bus.in_a_addr) : 0;
      m_wbdata  = m_ga ? int'(bus.in_a_data) : int'(bus.in_d_data);
      m_iss_rdy = (m_cnt[bus.in_iss_addr] < 3) || (m_wb && m_wbaddr == int'(bus.in_iss_addr));
      m_stall   = (m_cnt[bus.in_chk_op1_addr] > 0) || (m_cnt[bus.in_chk_op2_addr] > 0);
   endtask

   task automatic model_update();
      bit iss_fire;
      iss_fire = bus.in_iss_valid && m_iss_rdy;
      if (m_wb && m_cnt[m_wbaddr] == 0) m_err = 1'b1;
      for (int r = 0; r < 16; r++) begin
         int net;
         net = 0;
         if (iss_fire && int'(bus.in_iss_addr) == r) net = net + 1;
         if (m_wb && m_wbaddr == r) net = net - 1;
         m_cnt[r] = (m_cnt[r] + net < 0) ? 0 : m_cnt[r] + net;
      end
      m_we = m_wb;
      if (m_wb) begin
         m_waddr  = m_wbaddr;
         m_wdata  = m_wbdata;
         m_last_d = m_gd;
      end
   endtask

   function automatic logic [15:0] m_busy();
      logic [15:0] b;
      for (int r = 0; r < 16; r++) b[r] = (m_cnt[r] != 0);
      return b;
   endfunction

   task automatic tick();
      model_comb();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      bus.in_a_valid      = 1'b0;
      bus.in_a_addr       = '0;
      bus.in_a_data       = '0;
      bus.in_d_valid      = 1'b0;
      bus.in_d_data       = '0;
      bus.in_iss_valid    = 1'b0;
      bus.in_iss_addr     = '0;
      bus.in_chk_op1_addr = '0;
      bus.in_chk_op2_addr = '0;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      set_idle();
      rst = 1'b1;
      model_reset();
      #2;
      checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b exp 0", bus.out_we); end
      checks++; if (bus.out_waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr: got %0d exp 0", bus.out_waddr); end
      checks++; if (bus.out_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata: got %h exp 0000", bus.out_wdata); end
      checks++; if (bus.out_busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h exp 0000", bus.out_busy); end
      checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b exp 0", bus.out_err); end
      checks++; if (bus.out_iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %0b exp 1", bus.out_iss_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_single_write();
      do_reset();
      bus.in_iss_valid = 1'b1;
      bus.in_iss_addr  = 4'd5;
      #1;
      checks++; if (bus.out_iss_ready !== 1'b1) begin errors++; $display("FAIL sw_iss_ready: got %0b exp 1", bus.out_iss_ready); end
      tick();
      bus.in_iss_valid = 1'b0;
      checks++; if (bus.out_busy[5] !== 1'b1) begin errors++; $display("FAIL sw_busy_set: got %0b exp 1", bus.out_busy[5]); end
      bus.in_a_valid = 1'b1;
      bus.in_a_addr  = 4'd5;
      bus.in_a_data  = 16'h1234;
      #1;
      checks++; if (bus.out_a_ready !== 1'b1) begin errors++; $display("FAIL sw_a_ready: got %0b exp 1", bus.out_a_ready); end
      tick();
      bus.in_a_valid = 1'b0;
      checks++; if (bus.out_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %0b exp 1", bus.out_we); end
      checks++; if (bus.out_waddr !== 4'd5) begin errors++; $display("FAIL sw_waddr: got %0d exp 5", bus.out_waddr); end
      checks++; if (bus.out_wdata !== 16'h1234) begin errors++; $display("FAIL sw_wdata: got %h exp 1234", bus.out_wdata); end
      checks++; if (bus.out_busy[5] !== 1'b0) begin errors++; $display("FAIL sw_busy_clr: got %0b exp 0", bus.out_busy[5]); end
      checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL sw_err: got %0b exp 0", bus.out_err); end
      tick();
      checks++; if (bus.out_we !== 1'b0) begin errors++; $display("FAIL sw_we_one_cycle: got %0b exp 0", bus.out_we); end
   endtask

   task automatic test_round_robin();
      int exp_addr [4];
      exp_addr[0] = 3; exp_addr[1] = 0; exp_addr[2] = 3; exp_addr[3] = 0;
      do_reset();
      bus.in_a_valid = 1'b1;
      bus.in_a_addr  = 4'd3;
      bus.in_a_data  = 16'hAAAA;
      bus.in_d_valid = 1'b1;
      bus.in_d_data  = 16'h0040;
      for (int k = 0; k < 4; k++) begin
         logic exp_a;
         exp_a = (exp_addr[k] == 3);
         #1;
         checks++; if (bus.out_a_ready !== exp_a || bus.out_d_ready !== !exp_a) begin
            errors++; $display("FAIL rr_grant[%0d]: got a=%0b d=%0b exp a=%0b d=%0b", k,
                               bus.out_a_ready, bus.out_d_ready, exp_a, !exp_a);
         end
         tick();
         checks++; if (bus.out_we !== 1'b1 || int'(bus.out_waddr) != exp_addr[k] ||
                       bus.out_wdata !== (exp_a ? 16'hAAAA : 16'h0040)) begin
            errors++; $display("FAIL rr_write[%0d]: got we=%0b addr=%0d data=%h exp addr=%0d",
                               k, bus.out_we, bus.out_waddr, bus.out_wdata, exp_addr[k]);
         end
      end
      set_idle();
   endtask

   task automatic test_saturation();
      do_reset();
      bus.in_iss_valid = 1'b1;
      bus.in_iss_addr  = 4'd7;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (bus.out_iss_ready !== 1'b1) begin errors++; $display("FAIL sat_issue[%0d]: got %0b exp 1", k, bus.out_iss_ready); end
         tick();
      end
      #1;
      checks++; if (bus.out_iss_ready !== 1'b0) begin errors++; $display("FAIL sat_full: got %0b exp 0", bus.out_iss_ready); end
      tick();
      bus.in_a_valid = 1'b1;
      bus.in_a_addr  = 4'd7;
      bus.in_a_data  = 16'h0777;
      #1;
      checks++; if (bus.out_iss_ready !== 1'b1 || bus.out_a_ready !== 1'b1) begin
         errors++; $display("FAIL sat_bypass: got iss=%0b a=%0b exp iss=1 a=1", bus.out_iss_ready, bus.out_a_ready);
      end
      tick();
      bus.in_a_valid = 1'b0;
      #1;
      checks++; if (bus.out_iss_ready !== 1'b0 || bus.out_busy[7] !== 1'b1) begin
         errors++; $display("FAIL sat_still_full: got iss=%0b busy=%0b exp iss=0 busy=1", bus.out_iss_ready, bus.out_busy[7]);
      end
      set_idle();
   endtask

   task automatic test_stall();
      do_reset();
      bus.in_iss_valid = 1'b1;
      bus.in_iss_addr  = 4'd2;
      bus.in_chk_op2_addr = 4'd2;
      #1;
      checks++; if (bus.out_stall !== 1'b0) begin errors++; $display("FAIL stall_same_cycle: got %0b exp 0", bus.out_stall); end
      tick();
      bus.in_iss_valid = 1'b0;
      #1;
      checks++; if (bus.out_stall !== 1'b1) begin errors++; $display("FAIL stall_set: got %0b exp 1", bus.out_stall); end
      tick();
      bus.in_a_valid = 1'b1;
      bus.in_a_addr  = 4'd2;
      bus.in_a_data  = 16'h2222;
      #1;
      checks++; if (bus.out_stall !== 1'b1) begin errors++; $display("FAIL stall_at_handshake: got %0b exp 1", bus.out_stall); end
      tick();
      bus.in_a_valid = 1'b0;
      checks++; if (bus.out_we !== 1'b1 || bus.out_stall !== 1'b0) begin
         errors++; $display("FAIL stall_drop: got we=%0b stall=%0b exp we=1 stall=0", bus.out_we, bus.out_stall);
      end
      set_idle();
   endtask

   task automatic test_err();
      do_reset();
      bus.in_a_valid = 1'b1;
      bus.in_a_addr  = 4'd9;
      bus.in_a_data  = 16'h9999;
      tick();
      bus.in_a_valid = 1'b0;
      checks++; if (bus.out_we !== 1'b1 || bus.out_waddr !== 4'd9) begin
         errors++; $display("FAIL err_write: got we=%0b addr=%0d exp we=1 addr=9", bus.out_we, bus.out_waddr);
      end
      checks++; if (bus.out_err !== 1'b1 || bus.out_busy[9] !== 1'b0) begin
         errors++; $display("FAIL err_set: got err=%0b busy=%0b exp err=1 busy=0", bus.out_err, bus.out_busy[9]);
      end
      repeat (3) tick();
      checks++; if (bus.out_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b exp 1", bus.out_err); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.in_iss_valid = 1'b1;
      bus.in_iss_addr  = 4'd4;
      tick();
      bus.in_iss_valid = 1'b0;
      bus.in_iss_addr  = 4'd1;
      bus.in_a_valid   = 1'b1;
      bus.in_a_addr    = 4'd1;
      bus.in_a_data    = 16'h4444;
      tick();
      bus.in_a_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (bus.out_we !== 1'b0 || bus.out_busy !== 16'h0) begin
         errors++; $display("FAIL mid_reset: got we=%0b busy=%h exp we=0 busy=0000", bus.out_we, bus.out_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      bus.in_a_valid = 1'b1;
      bus.in_d_valid = 1'b1;
      #1;
      checks++; if (bus.out_a_ready !== 1'b1 || bus.out_d_ready !== 1'b0) begin
         errors++; $display("FAIL mid_reset_grant: got a=%0b d=%0b exp a=1 d=0", bus.out_a_ready, bus.out_d_ready);
      end
      set_idle();
      tick();
   endtask

   task automatic test_random();
      bit a_hold, d_hold;
      do_reset();
      a_hold = 1'b0;
      d_hold = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!a_hold) begin
            bus.in_a_valid = ($urandom_range(0, 2) != 0);
            bus.in_a_addr  = 4'($urandom_range(0, 3));
            bus.in_a_data  = 16'($urandom);
         end
         if (!d_hold) begin
            bus.in_d_valid = ($urandom_range(0, 3) == 0);
            bus.in_d_data  = 16'($urandom);
         end
         bus.in_iss_valid    = ($urandom_range(0, 1) != 0);
         bus.in_iss_addr     = 4'($urandom_range(0, 3));
         bus.in_chk_op1_addr = 4'($urandom_range(0, 4));
         bus.in_chk_op2_addr = 4'($urandom_range(0, 4));
         #1;
         model_comb();
         checks++; if (bus.out_a_ready !== m_ga || bus.out_d_ready !== m_gd ||
                       bus.out_iss_ready !== m_iss_rdy || bus.out_stall !== m_stall) begin
            errors++; $display("FAIL rand_comb[%0d]: got a=%0b d=%0b iss=%0b stall=%0b exp a=%0b d=%0b iss=%0b stall=%0b",
                               n, bus.out_a_ready, bus.out_d_ready, bus.out_iss_ready, bus.out_stall,
                               m_ga, m_gd, m_iss_rdy, m_stall);
         end
         a_hold = bus.in_a_valid && !m_ga;
         d_hold = bus.in_d_valid && !m_gd;
         tick();
         checks++; if (bus.out_we !== m_we || int'(bus.out_waddr) != m_waddr ||
                       int'(bus.out_wdata) != m_wdata || bus.out_busy !== m_busy() ||
                       bus.out_err !== m_err) begin
            errors++; $display("FAIL rand_state[%0d]: got we=%0b addr=%0d data=%h busy=%h err=%0b exp we=%0b addr=%0d data=%h busy=%h err=%0b",
                               n, bus.out_we, bus.out_waddr, bus.out_wdata, bus.out_busy, bus.out_err,
                               m_we, m_waddr, m_wdata[15:0], m_busy(), m_err);
         end
      end
      set_idle();
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      model_reset();
      test_reset();
      test_single_write();
      test_round_robin();
      test_saturation();
      test_stall();
      test_err();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler and scoreboard for the 16 x 16-bit register file of the pipelined processor. Arbitrates the single register-file write port between the load/ALU write-back requester and the divide unit's R0 result, and tracks outstanding destination writes so decode can stall operand reads on RAW hazards. Sits between the execute/memory stages and the register file; its write-port outputs drive the register file's write inputs directly.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- NREG, 16, number of registers
- CNT_W, 2, per-register outstanding-write counter width (max 3 pending)

Ports:
- CLOCK  in  1  single clock, all state updates on posedge
- in_rst  in  1  asynchronous, active-high reset
- in_a_valid  in  1  load/ALU write-back request
- in_a_addr  in  ADDR_W  destination register for requester A
- in_a_data  in  DATA_W  write data for requester A
- out_a_ready  out  1  requester A granted this cycle (combinational)
- in_d_valid  in  1  divide-unit R0 write request
- in_d_data  in  DATA_W  R0 write data
- out_d_ready  out  1  requester D granted this cycle (combinational)
- in_iss_valid  in  1  decode issues an instruction with a destination
- in_iss_addr  in  ADDR_W  claimed destination register
- out_iss_ready  out  1  issue accepted; low when claimed counter is saturated
- in_chk_op1_addr, in_chk_op2_addr  in  ADDR_W  operand addresses being read at decode
- out_stall  out  1  either checked operand has a pending write
- out_we  out  1  register-file write enable (registered)
- out_waddr  out  ADDR_W  register-file write address (registered)
- out_wdata  out  DATA_W  register-file write data (registered)
- out_busy  out  NREG  bit i set when counter i is non-zero
- out_err  out  1  sticky: write-back to a register with zero pending count

## Operation
- Handshake: transfer when valid && ready; requester holds valid, addr, data stable until accepted.
- Arbitration: one grant per cycle. Only one valid -> granted. Both valid -> round-robin via last_grant flag; grant goes to the requester not granted last; last_grant updates only on an actual transfer.
- Requester D always targets R0.
- Scoreboard: one CNT_W counter per register. Issue handshake (in_iss_valid && out_iss_ready) increments counter[in_iss_addr]; write-back handshake decrements counter[dest].
- Same-cycle increment and decrement of the same register: counter unchanged.
- out_iss_ready = counter[in_iss_addr] != 3, except when a same-cycle write-back to that register is accepted (then ready).
- Write-back with counter 0: counter stays 0, out_err set until reset; the write is still performed.
- out_stall = busy[in_chk_op1_addr] | busy[in_chk_op2_addr], combinational from counter state (not from same-cycle handshakes).
- in_rst mid-operation: all counters cleared, any in-flight registered write dropped (out_we forced 0), last_grant reset.

## Timing
- Reset values: out_we 0, out_waddr 0, out_wdata 0, out_busy 0, out_err 0, all counters 0, last_grant = D (A wins first conflict).
- Write latency 1: handshake at edge N -> out_we high with address and data for cycle N..N+1, exactly one cycle per transfer; back-to-back transfers give continuous out_we.
- Counter decrement at the handshake edge; out_stall for that register drops in the same cycle out_we is high, so the register file (negedge write) holds the value before the next posedge read.
- Issue increment at the handshake edge; out_stall asserts the following cycle.

## Structure
- Shared package rf_sched_pkg: DATA_W, ADDR_W, NREG, CNT_W, R0_ADDR = 0, CNT_MAX = 3, grant enum {GNT_A, GNT_D}.
- Sub-module rf_scoreboard: counter array, inc/dec merge, saturation, busy vector, out_err. Arbiter and write-port register stay in the top.

## Test plan
- Reset, then A writes 16'h1234 to R5 with counter 1 -> out_a_ready same cycle; next cycle out_we=1, out_waddr=5, out_wdata=16'h1234; busy[5] clears.
- A (R3, 16'hAAAA) and D (16'h0040) valid continuously -> grants alternate A, D, A, D; out_waddr sequence 3,0,3,0.
- Issue R7 three times -> out_iss_ready drops on fourth issue; write-back to R7 same cycle as fourth issue -> accepted, counter stays 3.
- Issue R2, then set in_chk_op2_addr=2 -> out_stall=1 until A write-back to R2; stall low in the out_we cycle.
- Write-back to R9 with counter 0 -> out_we=1, out_err=1 and stays 1; counter[9] remains 0.
- Assert in_rst the cycle after a handshake -> out_we=0 immediately, out_busy=0, next conflict granted to A.
